// File: rtl/cache_port_arbiter_if.sv
// Bundle of requester-side and cache-side signals for the unified cache port arbiter.
// master: the arbiter's view; slave: the requesters and the cache seen from outside.
interface cache_port_arbiter_if;
    logic          i_req;
    logic [31:0]   i_addr;
    logic [1023:0] i_data;
    logic          i_ack;
    logic          d_req;
    logic          d_we;
    logic [31:0]   d_addr;
    logic [1023:0] d_wdata;
    logic [1023:0] d_rdata;
    logic          d_ack;
    logic          c_read;
    logic          c_write;
    logic [31:0]   c_load_address;
    logic [31:0]   c_write_address;
    logic [1023:0] c_write_data;
    logic [1023:0] c_load_data;
    logic          c_ready;
    logic [1:0]    owner;
    logic          timeout_err;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, c_load_data, c_ready,
        output i_data, i_ack, d_rdata, d_ack, c_read, c_write, c_load_address,
               c_write_address, c_write_data, owner, timeout_err
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, c_load_data, c_ready,
        input  i_data, i_ack, d_rdata, d_ack, c_read, c_write, c_load_address,
               c_write_address, c_write_data, owner, timeout_err
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Shares one unified cache between instruction fetch (read-only) and the data stage (read/write).
// All outputs registered; a watchdog aborts reads the cache never completes.
module cache_port_arbiter #(
    parameter bit          DATA_PRIORITY  = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TW             = 8
) (
    input logic                  clk,
    input logic                  rst,
    cache_port_arbiter_if.master bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_I_RD = 2'd1;
    localparam logic [1:0] ST_D_RD = 2'd2;
    localparam logic [1:0] ST_D_WR = 2'd3;

    localparam logic [1:0] OWN_IDLE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_DR   = 2'b10;
    localparam logic [1:0] OWN_DW   = 2'b11;

    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic          last_d_q, last_d_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [31:0]   addr_q, addr_d;
    logic [1023:0] wdata_q, wdata_d;
    logic          c_read_q, c_read_d;
    logic          c_write_q, c_write_d;
    logic [1023:0] i_data_q, i_data_d;
    logic [1023:0] d_rdata_q, d_rdata_d;
    logic          i_ack_q, i_ack_d;
    logic          d_ack_q, d_ack_d;
    logic [1:0]    owner_q, owner_d;
    logic          terr_q, terr_d;

    logic          win_d;
    logic          rd_done;
    logic [1023:0] rd_data;

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        timer_d   = timer_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        c_read_d  = c_read_q;
        c_write_d = c_write_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;
        i_ack_d   = 1'b0;
        d_ack_d   = 1'b0;
        owner_d   = owner_q;
        terr_d    = terr_q;
        win_d     = 1'b0;
        rd_done   = 1'b0;
        rd_data   = '0;

        case (state_q)
            ST_IDLE: begin
                // The cycle an ack is visible is masked so a still-held req is not re-granted.
                if (!i_ack_q && !d_ack_q && (bus.i_req || bus.d_req)) begin
                    win_d    = bus.d_req && (!bus.i_req || DATA_PRIORITY || !last_d_q);
                    last_d_d = win_d;
                    timer_d  = '0;
                    if (win_d) begin
                        addr_d = bus.d_addr;
                        if (bus.d_we) begin
                            state_d   = ST_D_WR;
                            c_write_d = 1'b1;
                            wdata_d   = bus.d_wdata;
                            owner_d   = OWN_DW;
                        end else begin
                            state_d  = ST_D_RD;
                            c_read_d = 1'b1;
                            owner_d  = OWN_DR;
                        end
                    end else begin
                        addr_d   = bus.i_addr;
                        state_d  = ST_I_RD;
                        c_read_d = 1'b1;
                        owner_d  = OWN_I;
                    end
                end
            end

            ST_I_RD, ST_D_RD: begin
                // timer==0 marks the first read cycle, where c_ready may be stale from a prior hit.
                if (timer_q != '0 && bus.c_ready) begin
                    rd_done = 1'b1;
                    rd_data = bus.c_load_data;
                end else if (timer_q == TMO_LAST) begin
                    rd_done = 1'b1;
                    terr_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                if (rd_done) begin
                    c_read_d = 1'b0;
                    owner_d  = OWN_IDLE;
                    state_d  = ST_IDLE;
                    if (state_q == ST_I_RD) begin
                        i_ack_d  = 1'b1;
                        i_data_d = rd_data;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rd_data;
                    end
                end
            end

            ST_D_WR: begin
                // One strobe cycle, one turnaround cycle, then the ack.
                if (timer_q == '0) begin
                    c_write_d = 1'b0;
                    wdata_d   = '0;
                    timer_d   = timer_q + TW'(1);
                end else begin
                    d_ack_d = 1'b1;
                    owner_d = OWN_IDLE;
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            last_d_q  <= 1'b0;
            timer_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            c_read_q  <= 1'b0;
            c_write_q <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
            i_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            owner_q   <= OWN_IDLE;
            terr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            timer_q   <= timer_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            c_read_q  <= c_read_d;
            c_write_q <= c_write_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
            i_ack_q   <= i_ack_d;
            d_ack_q   <= d_ack_d;
            owner_q   <= owner_d;
            terr_q    <= terr_d;
        end
    end

    assign bus.i_data          = i_data_q;
    assign bus.i_ack           = i_ack_q;
    assign bus.d_rdata         = d_rdata_q;
    assign bus.d_ack           = d_ack_q;
    assign bus.c_read          = c_read_q;
    assign bus.c_write         = c_write_q;
    assign bus.c_load_address  = addr_q;
    assign bus.c_write_address = addr_q;
    assign bus.c_write_data    = wdata_q;
    assign bus.owner           = owner_q;
    assign bus.timeout_err     = terr_q;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Scoreboard bench: instance 0 uses data priority, instance 1 round-robin; a cache model
// per instance answers reads after a programmable number of cycles.
module tb_cache_port_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_s [2];
    logic          ireq  [2];
    logic [31:0]   iaddr [2];
    logic          dreq  [2];
    logic          dwe   [2];
    logic [31:0]   daddr [2];
    logic [1023:0] dwd   [2];
    int            lat   [2];
    bit            stale [2];

    wire           iack   [2];
    wire           dack   [2];
    wire           cread  [2];
    wire           cwrite [2];
    wire           terr   [2];
    wire [1023:0]  idata  [2];
    wire [1023:0]  drdata [2];
    wire [1023:0]  cwdata [2];
    wire [31:0]    claddr [2];
    wire [31:0]    cwaddr [2];
    wire [1:0]     owner  [2];

    int npass = 0;
    int ntot  = 0;

    typedef struct {
        int            g;
        bit            isd;
        bit            chk;
        logic [1023:0] data;
        bit            te;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    function automatic void check(string name, logic [1023:0] act, logic [1023:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h..%h want %h..%h", name,
                      act[1023:960], act[63:0], exp[1023:960], exp[63:0]);
    endfunction

    function automatic logic [1023:0] dflt(logic [31:0] a);
        if (a == 32'h40) return {128{8'hA5}};
        return {32{a ^ 32'h5A5A_0000}};
    endfunction

    function automatic void expect_ack(int g, bit isd, bit chk, logic [1023:0] data, bit te);
        exp_q.push_back('{g, isd, chk, data, te});
    endfunction

    for (genvar g = 0; g < 2; g++) begin : G
        cache_port_arbiter_if bus ();
        logic [1023:0] mem [logic [31:0]];
        int rcnt = 0;

        assign bus.i_req   = ireq[g];
        assign bus.i_addr  = iaddr[g];
        assign bus.d_req   = dreq[g];
        assign bus.d_we    = dwe[g];
        assign bus.d_addr  = daddr[g];
        assign bus.d_wdata = dwd[g];

        assign iack[g]   = bus.i_ack;
        assign dack[g]   = bus.d_ack;
        assign cread[g]  = bus.c_read;
        assign cwrite[g] = bus.c_write;
        assign terr[g]   = bus.timeout_err;
        assign idata[g]  = bus.i_data;
        assign drdata[g] = bus.d_rdata;
        assign cwdata[g] = bus.c_write_data;
        assign claddr[g] = bus.c_load_address;
        assign cwaddr[g] = bus.c_write_address;
        assign owner[g]  = bus.owner;

        cache_port_arbiter #(
            .DATA_PRIORITY (g == 0),
            .TIMEOUT_CYCLES(64),
            .TW            (8)
        ) u_dut (
            .clk(clk),
            .rst(rst_s[g]),
            .bus(bus)
        );

        // Cache model: ready after lat read cycles (0 = never); stale forces ready high and
        // serves garbage in the first read cycle.
        always @(negedge clk) begin
            if (bus.c_read) rcnt++;
            else rcnt = 0;
            if (bus.c_write) mem[bus.c_write_address] = bus.c_write_data;
            bus.c_ready = stale[g] || (bus.c_read && lat[g] != 0 && rcnt >= lat[g]);
            if (stale[g] && rcnt == 1) bus.c_load_data = '1;
            else if (mem.exists(bus.c_load_address)) bus.c_load_data = mem[bus.c_load_address];
            else bus.c_load_data = dflt(bus.c_load_address);
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (iack[g] || dack[g]) begin
                check("ack_exclusive", iack[g] & dack[g], 0);
                check("ack_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("ack_inst", g, mon_e.g);
                    check("ack_port", dack[g], mon_e.isd);
                    if (mon_e.chk) check("ack_data", dack[g] ? drdata[g] : idata[g], mon_e.data);
                    check("ack_timeout_err", terr[g], mon_e.te);
                end
            end
        end
    end

    task automatic wait_ack(input int g, input int maxc, output int cyc, output int who,
                            output int wcnt, output int rc, output logic [1:0] own1);
        cyc = 0; who = -1; wcnt = 0; rc = 0; own1 = 2'b00;
        while (cyc < maxc) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) own1 = owner[g];
            if (cwrite[g]) wcnt++;
            if (cread[g]) rc++;
            if (iack[g]) begin who = 0; break; end
            if (dack[g]) begin who = 1; break; end
        end
        check("ack_seen", who >= 0, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int cyc, who, wc, rc, wexp;
        logic [1:0] o1;
        for (int g = 0; g < 2; g++) begin
            rst_s[g] = 1'b1; ireq[g] = 1'b0; iaddr[g] = '0; dreq[g] = 1'b0;
            dwe[g] = 1'b0; daddr[g] = '0; dwd[g] = '0; lat[g] = 2; stale[g] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("rst_c_read", cread[g], 0);
            check("rst_c_write", cwrite[g], 0);
            check("rst_owner", owner[g], 0);
            check("rst_acks", {iack[g], dack[g]}, 0);
            check("rst_timeout_err", terr[g], 0);
            check("rst_addr", claddr[g], 0);
        end
        rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        @(negedge clk);

        // I-only read, ready on the second read cycle
        expect_ack(0, 0, 1, {128{8'hA5}}, 0);
        iaddr[0] = 32'h40; ireq[0] = 1'b1;
        wait_ack(0, 20, cyc, who, wc, rc, o1);
        ireq[0] = 1'b0;
        check("t1_latency", cyc, 3);
        check("t1_c_read_cycles", rc, 2);
        check("t1_owner_busy", o1, 2'b01);
        check("t1_owner_done", owner[0], 2'b00);
        check("t1_addr", claddr[0], 32'h40);
        @(negedge clk);

        // Tie with data priority: D first, I after the mask cycle
        expect_ack(0, 1, 1, {32{32'h5A5A_0080}}, 0);
        expect_ack(0, 0, 1, {32{32'h5A5A_0044}}, 0);
        iaddr[0] = 32'h44; daddr[0] = 32'h80; dwe[0] = 1'b0;
        ireq[0] = 1'b1; dreq[0] = 1'b1;
        wait_ack(0, 20, cyc, who, wc, rc, o1);
        dreq[0] = 1'b0;
        check("t2_first_winner", who, 1);
        check("t2_d_latency", cyc, 3);
        check("t2_owner_d", o1, 2'b10);
        wait_ack(0, 20, cyc, who, wc, rc, o1);
        ireq[0] = 1'b0;
        check("t2_second_winner", who, 0);
        check("t2_i_latency_after_d", cyc, 4);
        @(negedge clk);

        // Round-robin ties alternate D, I, D
        for (int k = 0; k < 3; k++) begin
            wexp = (k == 1) ? 0 : 1;
            expect_ack(1, wexp[0], 1, (wexp == 1) ? dflt(32'h80) : dflt(32'h44), 0);
            iaddr[1] = 32'h44; daddr[1] = 32'h80; dwe[1] = 1'b0;
            ireq[1] = 1'b1; dreq[1] = 1'b1;
            wait_ack(1, 20, cyc, who, wc, rc, o1);
            ireq[1] = 1'b0; dreq[1] = 1'b0;
            check("rr_winner", who, wexp);
            check("rr_latency", cyc, 3);
            @(negedge clk);
        end

        // Write then read back
        expect_ack(0, 1, 0, '0, 0);
        daddr[0] = 32'h100; dwe[0] = 1'b1; dwd[0] = {32{32'hDEADBEEF}}; dreq[0] = 1'b1;
        wait_ack(0, 20, cyc, who, wc, rc, o1);
        dreq[0] = 1'b0; dwe[0] = 1'b0;
        check("t3_wr_port", who, 1);
        check("t3_wr_latency", cyc, 3);
        check("t3_c_write_cycles", wc, 1);
        check("t3_owner_wr", o1, 2'b11);
        check("t3_load_addr", claddr[0], 32'h100);
        check("t3_write_addr", cwaddr[0], 32'h100);
        check("t3_c_read_during_wr", rc, 0);
        @(negedge clk);
        expect_ack(0, 1, 1, {32{32'hDEADBEEF}}, 0);
        dreq[0] = 1'b1;
        wait_ack(0, 20, cyc, who, wc, rc, o1);
        dreq[0] = 1'b0;
        check("t3_rd_latency", cyc, 3);
        @(negedge clk);

        // Stale ready from a previous hit must be ignored in the first read cycle
        stale[0] = 1'b1; lat[0] = 1;
        @(negedge clk);
        expect_ack(0, 0, 1, {32{32'h5A5A_0048}}, 0);
        iaddr[0] = 32'h48; ireq[0] = 1'b1;
        wait_ack(0, 20, cyc, who, wc, rc, o1);
        ireq[0] = 1'b0;
        check("t4_latency", cyc, 3);
        stale[0] = 1'b0; lat[0] = 2;
        @(negedge clk);

        // Watchdog abort, then sticky error across a normal read
        lat[0] = 0;
        expect_ack(0, 1, 1, '0, 1);
        daddr[0] = 32'h200; dwe[0] = 1'b0; dreq[0] = 1'b1;
        wait_ack(0, 200, cyc, who, wc, rc, o1);
        dreq[0] = 1'b0;
        check("t5_abort_latency", cyc, 65);
        check("t5_c_read_cycles", rc, 64);
        check("t5_c_read_dropped", cread[0], 0);
        lat[0] = 2;
        @(negedge clk);
        expect_ack(0, 0, 1, {128{8'hA5}}, 1);
        iaddr[0] = 32'h40; ireq[0] = 1'b1;
        wait_ack(0, 20, cyc, who, wc, rc, o1);
        ireq[0] = 1'b0;
        check("t5_sticky_err", terr[0], 1);
        @(negedge clk);

        // Asynchronous reset mid read discards the transaction
        lat[1] = 0;
        daddr[1] = 32'h300; dwe[1] = 1'b0; dreq[1] = 1'b1;
        repeat (3) @(negedge clk);
        check("t6_in_read", cread[1], 1);
        #2 rst_s[1] = 1'b1;
        #1;
        check("t6_rst_c_read", cread[1], 0);
        check("t6_rst_owner", owner[1], 0);
        check("t6_rst_acks", {iack[1], dack[1]}, 0);
        check("t6_rst_addr", claddr[1], 0);
        check("t6_rst_rdata", drdata[1], 0);
        dreq[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst_s[1] = 1'b0; lat[1] = 2;
        repeat (3) @(negedge clk);
        expect_ack(1, 1, 1, dflt(32'h80), 0);
        iaddr[1] = 32'h44; daddr[1] = 32'h80; ireq[1] = 1'b1; dreq[1] = 1'b1;
        wait_ack(1, 20, cyc, who, wc, rc, o1);
        ireq[1] = 1'b0; dreq[1] = 1'b0;
        check("t6_tie_after_rst", who, 1);
        check("t6_owner", o1, 2'b10);
        repeat (3) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
